// File: rtl/odd_par_tx_ctrl_if.sv
// Request handshake between a word producer and the odd-parity serial transmitter.
interface odd_par_tx_ctrl_if #(
    parameter int unsigned N = 8
) ();
    logic [N-1:0] data_in;
    logic         valid_in;
    logic         ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/odd_par_tx_ctrl.sv
// Serial transmitter: start bit, N data bits LSB first, odd parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT clocks. A frame is accepted only while idle.
module odd_par_tx_ctrl #(
    parameter int unsigned N            = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    odd_par_tx_ctrl_if.slave     bus,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0] bit_idx_q, bit_idx_d;
    logic [N-1:0]    data_q, data_d;
    logic            done_q, done_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            bit_end;

    // Ready is also gated by rst so no word is taken during a reset cycle.
    assign bus.ready_out = (state_q == StIdle) && !rst;
    assign bit_end       = (bit_cnt_q == CntLast);

    // Next-state logic: bit timing, state sequencing, word latch and frame counting.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Counter wraps at the end of every bit, which is also where states change.
        if (state_q != StIdle) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    state_d   = StStart;
                    data_d    = bus.data_in;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == IdxLast) begin
                        state_d   = StParity;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Serial line level decoded from state; parity uses the latched word only.
    always_comb begin
        tx_out = 1'b1;
        unique case (state_q)
            StStart:  tx_out = 1'b0;
            StData:   tx_out = data_q[bit_idx_q];
            StParity: tx_out = ~^data_q;
            default:  tx_out = 1'b1;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_odd_par_tx_ctrl.sv
// Bench for odd_par_tx_ctrl: two instances (N=8/CLKS_PER_BIT=4 and N=2/CLKS_PER_BIT=1)
// compared every cycle against a bit-stream model of the frame.
module tb_odd_par_tx_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic        tx0, busy0, done0;
    logic [15:0] fcnt0;
    logic        tx1, busy1, done1;
    logic [15:0] fcnt1;

    odd_par_tx_ctrl_if #(.N(8)) if0 ();
    odd_par_tx_ctrl_if #(.N(2)) if1 ();

    odd_par_tx_ctrl #(.N(8), .CLKS_PER_BIT(4)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if0),
        .tx_out    (tx0),
        .busy      (busy0),
        .done      (done0),
        .frame_cnt (fcnt0)
    );

    odd_par_tx_ctrl #(.N(2), .CLKS_PER_BIT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if1),
        .tx_out    (tx1),
        .busy      (busy1),
        .done      (done1),
        .frame_cnt (fcnt1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a frame is a sequence of bit slots, each CLKS_PER_BIT clocks long.
    logic [7:0]  w0, w1;
    int          pos0 = 0, len0 = 0, pos1 = 0, len1 = 0;
    logic        ed0 = 1'b0, ed1 = 1'b0;
    logic [15:0] ec0 = 16'd0, ec1 = 16'd0;
    int          acc0 = 0;
    int          busy_seen0 = 0, done_seen0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Bit slot b of a frame carrying word w of width n.
    function automatic logic frame_bit(input logic [7:0] w, input int n, input int b);
        logic [7:0] m;
        m = w & 8'((1 << n) - 1);
        if (b == 0) return 1'b0;
        else if (b <= n) return w[b-1];
        else if (b == n + 1) return ~^m;
        else return 1'b1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            pos0 = 0; len0 = 0; ed0 = 1'b0; ec0 = 16'd0;
            pos1 = 0; len1 = 0; ed1 = 1'b0; ec1 = 16'd0;
        end else begin
            if (pos0 == len0) begin
                ed0 = 1'b0;
                if (if0.valid_in) begin
                    w0 = if0.data_in; pos0 = 0; len0 = (8 + 3) * 4; acc0++;
                end
            end else begin
                pos0++;
                ed0 = (pos0 == len0);
                if (ed0) ec0 = ec0 + 16'd1;
            end
            if (pos1 == len1) begin
                ed1 = 1'b0;
                if (if1.valid_in) begin
                    w1 = {6'b0, if1.data_in}; pos1 = 0; len1 = (2 + 3) * 1;
                end
            end else begin
                pos1++;
                ed1 = (pos1 == len1);
                if (ed1) ec1 = ec1 + 16'd1;
            end
        end
        @(negedge clk);
        check("tx0",    32'(tx0),    32'((pos0 < len0) ? frame_bit(w0, 8, pos0 / 4) : 1'b1));
        check("busy0",  32'(busy0),  32'(pos0 < len0));
        check("done0",  32'(done0),  32'(ed0));
        check("ready0", 32'(if0.ready_out), 32'((pos0 == len0) && !rst));
        check("fcnt0",  32'(fcnt0),  32'(ec0));
        check("tx1",    32'(tx1),    32'((pos1 < len1) ? frame_bit(w1, 2, pos1) : 1'b1));
        check("busy1",  32'(busy1),  32'(pos1 < len1));
        check("done1",  32'(done1),  32'(ed1));
        check("ready1", 32'(if1.ready_out), 32'((pos1 == len1) && !rst));
        check("fcnt1",  32'(fcnt1),  32'(ec1));
        busy_seen0 += int'(busy0);
        done_seen0 += int'(done0);
    endtask

    task automatic send0(input logic [7:0] d, input int wait_cycles);
        if0.valid_in = 1'b1;
        if0.data_in  = d;
        cycle();
        if0.valid_in = 1'b0;
        repeat (wait_cycles) begin
            if0.data_in = 8'($urandom);
            cycle();
        end
    endtask

    initial begin
        int base;
        logic [7:0] pvals [4];
        pvals[0] = 8'h00; pvals[1] = 8'h07; pvals[2] = 8'hFF; pvals[3] = 8'h01;

        rst = 1'b1;
        if0.valid_in = 1'b0; if0.data_in = 8'h00;
        if1.valid_in = 1'b0; if1.data_in = 2'b00;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // 0xA5: 44 busy cycles, one done pulse, count of one.
        busy_seen0 = 0; done_seen0 = 0;
        send0(8'hA5, 50);
        check("a5_busy_cycles", 32'(busy_seen0), 32'd44);
        check("a5_done_pulses", 32'(done_seen0), 32'd1);
        check("a5_frame_cnt",   32'(fcnt0),      32'd1);

        // Parity corner words.
        for (int i = 0; i < 4; i++) send0(pvals[i], 46);

        // Back-to-back with valid held high: 0x3C then 0xC3.
        base = acc0;
        busy_seen0 = 0;
        for (int i = 0; i < 100; i++) begin
            if0.valid_in = (acc0 < base + 2);
            if0.data_in  = (acc0 == base) ? 8'h3C : 8'hC3;
            cycle();
        end
        if0.valid_in = 1'b0;
        check("b2b_busy_cycles", 32'(busy_seen0), 32'd88);
        check("b2b_frame_cnt",   32'(fcnt0),      32'd7);

        // Reset during data bit 3 of 0x55.
        send0(8'h55, 0);
        for (int i = 0; i < 40 && pos0 != 17; i++) cycle();
        check("rst_reached_bit3", 32'(pos0), 32'd17);
        rst = 1'b1;
        cycle();
        check("rst_abort_tx",   32'(tx0),   32'd1);
        check("rst_abort_busy", 32'(busy0), 32'd0);
        check("rst_abort_cnt",  32'(fcnt0), 32'd0);
        rst = 1'b0;
        cycle();
        check("rst_ready_after", 32'(if0.ready_out), 32'd1);

        // N=2, one clock per bit, word 2'b10.
        if1.valid_in = 1'b1; if1.data_in = 2'b10;
        cycle();
        if1.valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("n2_seq", 32'(tx1), 32'(frame_bit(8'h02, 2, i)));
            cycle();
        end
        check("n2_done", 32'(done1), 32'd1);

        // Counter wrap: preload 0xFFFF, then one frame with data toggling mid-frame.
        force dut1.frame_cnt_q = 16'hFFFF;
        ec1 = 16'hFFFF;
        cycle();
        release dut1.frame_cnt_q;
        cycle();
        if1.valid_in = 1'b1; if1.data_in = 2'b01;
        cycle();
        if1.valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if1.data_in = ~if1.data_in;
            cycle();
        end
        check("wrap_cnt", 32'(fcnt1), 32'h0000);

        // Random traffic on both instances with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            if0.valid_in = $urandom_range(0, 1) == 1;
            if0.data_in  = 8'($urandom);
            if1.valid_in = $urandom_range(0, 2) == 0;
            if1.data_in  = 2'($urandom);
            cycle();
        end
        rst = 1'b0;
        if0.valid_in = 1'b0;
        if1.valid_in = 1'b0;
        repeat (50) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
